// File: rtl/dist_rd_ctrl.sv
// dist_rd_ctrl: read sequencer and write-port arbiter for the 16-read-port
// distance SRAM bank. Streams consecutive 16-word beats with a valid/ready
// handshake and blocks the external writer while a job is in flight.
module dist_rd_ctrl #(
  parameter int ADDR_SPACE = 16,
  parameter int BEAT_W     = 12,
  parameter int D          = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_SPACE-1:0] base_addr,
  input  logic [BEAT_W-1:0]     num_beats,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_SPACE-1:0] raddr0,
  output logic [ADDR_SPACE-1:0] raddr1,
  output logic [ADDR_SPACE-1:0] raddr2,
  output logic [ADDR_SPACE-1:0] raddr3,
  output logic [ADDR_SPACE-1:0] raddr4,
  output logic [ADDR_SPACE-1:0] raddr5,
  output logic [ADDR_SPACE-1:0] raddr6,
  output logic [ADDR_SPACE-1:0] raddr7,
  output logic [ADDR_SPACE-1:0] raddr8,
  output logic [ADDR_SPACE-1:0] raddr9,
  output logic [ADDR_SPACE-1:0] raddr10,
  output logic [ADDR_SPACE-1:0] raddr11,
  output logic [ADDR_SPACE-1:0] raddr12,
  output logic [ADDR_SPACE-1:0] raddr13,
  output logic [ADDR_SPACE-1:0] raddr14,
  output logic [ADDR_SPACE-1:0] raddr15,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BEAT_W-1:0]     out_beat,
  input  logic                  wr_req,
  input  logic [ADDR_SPACE-1:0] wr_addr,
  input  logic [D-1:0]          wr_data,
  output logic                  wr_gnt,
  output logic                  wsb,
  output logic [ADDR_SPACE-1:0] waddr,
  output logic [D-1:0]          wdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_SPACE-1:0] base_q;
  logic [BEAT_W-1:0]     nb_q;
  logic [BEAT_W-1:0]     ip;
  logic                  issue_en;
  logic [BEAT_W-1:0]     sel;
  logic [ADDR_SPACE-1:0] row;
  logic [ADDR_SPACE-1:0] raddr_v [16];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: zero-length jobs skip straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_beats == '0) ? DONE : READ;
      READ:    if (issue_en && (ip == nb_q - BEAT_W'(1))) state_nxt = DRAIN;
      DRAIN:   if (out_valid && out_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; the writer only gets the port while idle
  always_comb begin
    busy     = (state == READ) || (state == DRAIN);
    done     = (state == DONE);
    wr_gnt   = wr_req && (state == IDLE);
    wsb      = !wr_gnt;
    issue_en = (state == READ) && (!out_valid || out_ready);
  end

  // Job capture, issue pointer and the beat register aligned with bank rdata
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      nb_q      <= '0;
      ip        <= '0;
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            nb_q   <= num_beats;
            ip     <= '0;
          end
        end
        READ: begin
          if (issue_en) begin
            out_valid <= 1'b1;
            out_beat  <= ip;
            ip        <= ip + BEAT_W'(1);
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Stalled beat re-presents its own addresses so the registered bank output
  // holds steady; the ready-dependent mux sits ahead of a single adder.
  always_comb begin
    sel = (out_valid && !out_ready) ? out_beat : ip;
    row = base_q + (ADDR_SPACE'(sel) << 4);
    for (int unsigned k = 0; k < 16; k++) begin
      raddr_v[k] = row + ADDR_SPACE'(k);
    end
  end

  assign raddr0  = raddr_v[0];
  assign raddr1  = raddr_v[1];
  assign raddr2  = raddr_v[2];
  assign raddr3  = raddr_v[3];
  assign raddr4  = raddr_v[4];
  assign raddr5  = raddr_v[5];
  assign raddr6  = raddr_v[6];
  assign raddr7  = raddr_v[7];
  assign raddr8  = raddr_v[8];
  assign raddr9  = raddr_v[9];
  assign raddr10 = raddr_v[10];
  assign raddr11 = raddr_v[11];
  assign raddr12 = raddr_v[12];
  assign raddr13 = raddr_v[13];
  assign raddr14 = raddr_v[14];
  assign raddr15 = raddr_v[15];

  assign waddr = wr_addr;
  assign wdata = wr_data;

endmodule

// File: doc/dist_rd_ctrl.md
# dist_rd_ctrl

Read sequencer and write-port arbiter for the distance SRAM bank (16 read ports, 1 write port, registered read). On a start command it streams a job of consecutive 16-word beats: one address per read port per beat. It pairs each beat with a valid/ready handshake toward the graph datapath, which takes beat data directly from the bank's rdata0..rdata15. While a job is running it also holds off the external writer so reads never race writes.

## Interface
- ADDR_SPACE, 16: bank address width; all address arithmetic is modulo 2^ADDR_SPACE.
- BEAT_W, 12: width of the beat count and beat index.
- D, 256: bank word width, used for wdata pass-through.
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  job request; sampled only in IDLE.
- base_addr  in  ADDR_SPACE  job base word address; captured on accepted start.
- num_beats  in  BEAT_W  beats in job; captured on accepted start.
- busy  out  1  high in READ or DRAIN.
- done  out  1  one-cycle pulse at job completion.
- raddr0..raddr15  out  ADDR_SPACE each  bank read addresses.
- out_valid  out  1  bank rdata holds beat out_beat.
- out_ready  in  1  downstream accepts current beat.
- out_beat  out  BEAT_W  index of beat on bank rdata.
- wr_req  in  1  writer request.
- wr_addr  in  ADDR_SPACE  write address.
- wr_data  in  D  write data.
- wr_gnt  out  1  write performed this cycle.
- wsb  out  1  bank write enable, active-low; equals ~wr_gnt.
- waddr  out  ADDR_SPACE  equals wr_addr.
- wdata  out  D  equals wr_data.

## Operation
- States: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 latches base/num_beats, clears issue pointer ip, moves to READ. If num_beats=0, moves to DONE instead.
  - READ: issue_en = !out_valid || out_ready. On issue_en: out_valid<=1, out_beat<=ip, ip<=ip+1. If ip==num_beats-1 on that issue, moves to DRAIN.
  - DRAIN: no issue. When out_valid && out_ready: out_valid<=0, move to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- In READ, an accepted beat with no new issue cannot occur, because issue_en covers it.
- Address select: sel = (out_valid && !out_ready) ? out_beat : ip.
  - raddr_k = base + sel*16 + k, for k=0..15, truncated to ADDR_SPACE; wraps past the top of the bank.
  - When downstream stalls, this re-presents the held beat's addresses, so the bank recaptures identical data and rdata stays stable.
  - In IDLE and DONE, sel uses ip, and the addresses are don't-care.
- Write arbitration: wr_gnt = wr_req && (state==IDLE), combinational. No writes are granted during READ, DRAIN or DONE; the writer holds wr_req.
- start while busy: ignored, with no queueing.
- start and wr_req in the same IDLE cycle: both are accepted. The write lands at that edge and is visible to beat 0.
- Reset:
  - state IDLE; busy=0, done=0, out_valid=0, out_beat=0, ip=0, wr_gnt follows wr_req.
  - Reset mid-job aborts the job with no done pulse.

## Timing
- Start accepted in cycle t. Beat-0 addresses are driven in t+1. The bank captures them at the end of t+1, and out_valid=1 / out_beat=0 appear in t+2, aligned with the bank's registered rdata.
- With out_ready held high, throughput is 1 beat/cycle; beat b is valid in cycle t+2+b.
- Job of N≥1 beats with no stall: the last beat is valid in cycle t+1+N (DRAIN), done pulses in t+2+N, and the block is back in IDLE in t+3+N.
- num_beats=0: done pulses in t+1, and the block is in IDLE in t+2.
- out_ready→raddr is a combinational path; it is kept shallow (2:1 mux before the adder).
- busy is combinational from state and drops the cycle done is high.

## Test plan
- Basic stream: base=0x0100, N=4, out_ready=1.
  - out_valid is high in t+2..t+5 with out_beat 0..3.
  - Beat 2 raddr0=0x0120 and raddr15=0x012F; data matches preloaded mem.
  - done pulses in t+6.
- Backpressure: N=3; out_ready=0 for 3 cycles while beat 1 is valid.
  - out_beat stays 1 and raddr0..15 stay at base+16..base+31 during the stall.
  - rdata is unchanged and no beat is lost or duplicated after release.
- Wrap: base=0xFFF8, N=2.
  - Beat 0 raddr8=0x0000; beat 1 raddr0=0x0008.
- Zero length: start with N=0.
  - No out_valid; done pulses in t+1; busy stays 0.
- Write arbitration: wr_req held from mid-job.
  - wr_gnt=0 and wsb=1 until IDLE, then wr_gnt=1 and the write lands.
  - In IDLE, start+wr_req to address base+5 in the same cycle: beat 0 rdata5 returns the new value.
- Reset and ignored start: rst asserted during beat 1 of an N=8 job.
  - Next cycle: out_valid=0, busy=0, and done never pulses.
  - A new start then runs normally.
  - A start pulse during READ is ignored (no re-latch of base).
